// File: rtl/mc_mem_pkg.sv
// mc_mem_pkg: shared definitions for the multicycle-core memory interface.
//   - FSM state encodings (IDLE/REQ/WAIT/RESP)
//   - funct3 size/sign codes for loads and stores
//   - latched request struct
//   - helpers: request legality, store byte enables, store lane replication
package mc_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } mem_req_t;

  // Illegal size codes, or a half/word access that is not naturally aligned.
  // Store codes share the load encoding, so one check covers both.
  function automatic logic req_bad(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b011, 3'b110, 3'b111: return 1'b1;
      LH, LHU:                return a[0];
      LW:                     return (a != 2'b00);
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data across every lane it may land in;
  // the byte enables pick the live lane.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load extraction.
//   rdata   : raw 32-bit memory word
//   addr_lo : byte offset within the word
//   funct3  : load size/sign code
//   result  : byte/half selected by offset and sign/zero extended, or the word
module mem_load_align
  import mc_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (addr_lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      result = {{24{b[7]}}, b};
      LH:      result = {{16{h[15]}}, h};
      LBU:     result = {24'h0, b};
      LHU:     result = {16'h0, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mc_mem_if.sv
// mc_mem_if: memory interface between the multicycle controller and a
// gnt/rvalid memory port. One access in flight; the controller is stalled
// until the one-cycle rsp_valid pulse.
//   Controller side: req_valid/req_we/req_addr/req_wdata/req_funct3 in,
//                    stall, rsp_valid, rsp_rdata, rsp_err out.
//   Memory side:     mem_req/mem_we/mem_addr/mem_wdata/mem_be out,
//                    mem_gnt, mem_rvalid, mem_rdata in.
// Build option: define MEM_IF_TIMEOUT_EN to abort an access that spends
// TIMEOUT_CYCLES cycles in REQ+WAIT (error response, no data). Without it the
// FSM waits indefinitely and TIMEOUT_CYCLES has no effect.
module mc_mem_if
  import mc_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mc_mem_if: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]  state, state_d;
  mem_req_t    req_q;
  logic        bad;
  logic        to_fire;
  logic [31:0] load_res;

  assign bad = req_bad(req_funct3, req_addr[1:0]);

  assign stall     = (state == ST_IDLE && req_valid) || state == ST_REQ || state == ST_WAIT;
  assign rsp_valid = (state == ST_RESP);
  assign mem_req   = (state == ST_REQ);
  // Strobes only live while the request is on the bus; address/data are the
  // latched request (zero after reset).
  assign mem_we    = mem_req & req_q.we;
  assign mem_be    = mem_req ? store_be(req_q.funct3, req_q.addr[1:0]) : 4'b0000;
  assign mem_addr  = {req_q.addr[31:2], 2'b00};
  assign mem_wdata = store_data(req_q.funct3, req_q.wdata);

  mem_load_align u_align (
    .rdata   (mem_rdata),
    .addr_lo (req_q.addr[1:0]),
    .funct3  (req_q.funct3),
    .result  (load_res)
  );

`ifdef MEM_IF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  // Counts every cycle spent in REQ+WAIT. Normal progress wins over the
  // abort, so an access granted on its last cycle still times out in WAIT.
  always_ff @(posedge clk) begin
    if (reset)                                  to_cnt <= '0;
    else if (state != ST_REQ && state_d == ST_REQ) to_cnt <= '0;
    else if (state == ST_REQ || state == ST_WAIT)  to_cnt <= to_cnt + 1'b1;
  end

  assign to_fire = ((state == ST_REQ && !mem_gnt) || (state == ST_WAIT && !mem_rvalid)) &&
                   (int'(to_cnt) >= TIMEOUT_CYCLES - 1);
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (req_valid)  state_d = bad ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_gnt)    state_d = ST_WAIT;
      ST_WAIT: if (mem_rvalid) state_d = ST_RESP;
      default:                 state_d = ST_IDLE;
    endcase
    if (to_fire) state_d = ST_RESP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && req_valid) begin
        req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
        if (bad) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if (state == ST_WAIT && mem_rvalid) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= req_q.we ? 32'h0 : load_res;
      end
      if (to_fire) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mc_mem_if.sv
module tb_mc_mem_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];   // {err, rdata}
  logic [32:0] mon_e;

  // memory responder config/state
  bit          mem_auto;
  bit          pending;
  int          gnt_dly, rv_dly, gcnt, rcnt;
  logic [31:0] mem_word;

  // first-REQ-cycle capture of the memory request
  bit          cap_seen;
  logic        cap_stall0, cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_wd, cap_ma;

  always #5 clk = ~clk;

  mc_mem_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  function automatic logic [32:0] model(input logic we, input logic [31:0] addr,
                                        input logic [2:0] f3, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 ||
        ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) ||
        (f3 == 3'd2 && addr[1:0] != 2'd0))
      return {1'b1, 32'h0};
    if (we) return {1'b0, 32'h0};
    b = w[8*addr[1:0] +: 8];
    h = w[16*addr[1] +: 16];
    case (f3)
      3'd0:    return {1'b0, {24{b[7]}}, b};
      3'd1:    return {1'b0, {16{h[15]}}, h};
      3'd4:    return {1'b0, 24'h0, b};
      3'd5:    return {1'b0, 16'h0, h};
      default: return {1'b0, w};
    endcase
  endfunction

  // scoreboard: every rsp_valid pops one expected response
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got err=%b rdata=%h, no response expected", rsp_err, rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== mon_e) begin
          errors++;
          $display("FAIL rsp_data: got err=%b rdata=%h expected err=%b rdata=%h",
                   rsp_err, rsp_rdata, mon_e[32], mon_e[31:0]);
        end
      end
    end
  end

  // memory responder: gnt after gnt_dly REQ cycles, rvalid rv_dly cycles later (-1 = never)
  always begin
    @(posedge clk); #1;
    if (reset) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; pending = 0; gcnt = 0; rcnt = 0;
    end else if (mem_auto) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (pending) begin
        if (rv_dly >= 0 && rcnt == rv_dly) begin
          mem_rvalid = 1'b1; mem_rdata = mem_word; pending = 0;
        end else rcnt++;
      end else if (mem_req) begin
        if (gnt_dly >= 0 && gcnt == gnt_dly) begin
          mem_gnt = 1'b1; pending = 1; gcnt = 0; rcnt = 0;
        end else gcnt++;
      end
    end
  end

  task automatic set_mem(input int g, input int r, input logic [31:0] w);
    gnt_dly = g; rv_dly = r; mem_word = w; gcnt = 0; rcnt = 0; pending = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_auto = 1;
  endtask

  // Drives one request from IDLE, scrambles req_* while busy, returns cycles
  // from request sample to rsp_valid. Ends one cycle after RESP.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit expect_to, output int lat);
    bit seen;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    if (expect_to) exp_q.push_back({1'b1, 32'h0});
    else           exp_q.push_back(model(we, addr, f3, mem_word));
    cap_seen = 0; lat = 0; seen = 0;
    @(negedge clk);
    cap_stall0 = stall;
    while (!seen && lat < 50) begin
      if (rsp_valid) seen = 1;
      else begin
        if (mem_req && !cap_seen) begin
          cap_seen = 1; cap_be = mem_be; cap_wd = mem_wdata; cap_ma = mem_addr; cap_we = mem_we;
        end
        @(posedge clk); #1;
        lat++;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL xact_bound: no rsp_valid after %0d cycles, required within 50", lat);
    end
    @(posedge clk); #1;
    req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_funct3 = 3'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_auto = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stall, rsp_valid, rsp_err, mem_req, mem_we, mem_be} !== 9'h0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000000",
                         {stall, rsp_valid, rsp_err, mem_req, mem_we, mem_be});
    end
    checks++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected all 0",
                         rsp_rdata, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_lw;
    int lat;
    set_mem(0, 0, 32'hDEADBEEF);
    xact(1'b0, 3'b010, 32'h100, 32'h0, 0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", lat); end
    checks++;
    if ({cap_stall0, cap_we, cap_be, cap_ma} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      errors++; $display("FAIL lw_memreq: got stall=%b we=%b be=%b addr=%h expected 1 0 1111 00000100",
                         cap_stall0, cap_we, cap_be, cap_ma);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, stall, rsp_err, rsp_rdata} !== {3'b000, 32'hDEADBEEF}) begin
      errors++; $display("FAIL lw_hold: got v=%b stall=%b err=%b rdata=%h expected 0 0 0 deadbeef",
                         rsp_valid, stall, rsp_err, rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_loads;
    logic [2:0]  f3s[7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0, 3'd5, 3'd2};
    logic [31:0] ads[7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100, 32'h100};
    int lat;
    set_mem(0, 0, 32'h80123456);
    for (int i = 0; i < 7; i++) begin
      xact(1'b0, f3s[i], ads[i], 32'h0, 0, lat);
      checks++;
      if ({cap_seen, cap_ma, lat} !== {1'b1, 32'h100, 32'd3}) begin
        errors++; $display("FAIL load_addr[%0d]: got seen=%b addr=%h lat=%0d expected 1 00000100 3",
                           i, cap_seen, cap_ma, lat);
      end
    end
  endtask

  task automatic test_stores;
    logic [2:0]  f3s[5] = '{3'd1, 3'd0, 3'd1, 3'd2, 3'd0};
    logic [31:0] ads[5] = '{32'h0A2, 32'h0A1, 32'h0A0, 32'h0A4, 32'h0A3};
    logic [31:0] wds[5] = '{32'h0000BEEF, 32'h1234565A, 32'hFFFF1234, 32'hCAFEF00D, 32'h00000077};
    logic [3:0]  ebe[5] = '{4'b1100, 4'b0010, 4'b0011, 4'b1111, 4'b1000};
    logic [31:0] ewd[5] = '{32'hBEEFBEEF, 32'h5A5A5A5A, 32'h12341234, 32'hCAFEF00D, 32'h77777777};
    logic [31:0] ema[5] = '{32'h0A0, 32'h0A0, 32'h0A0, 32'h0A4, 32'h0A0};
    int lat;
    set_mem(0, 0, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      xact(1'b1, f3s[i], ads[i], wds[i], 0, lat);
      checks++;
      if ({cap_we, cap_be, cap_wd, cap_ma} !== {1'b1, ebe[i], ewd[i], ema[i]}) begin
        errors++; $display("FAIL store[%0d]: got we=%b be=%b wdata=%h addr=%h expected 1 %b %h %h",
                           i, cap_we, cap_be, cap_wd, cap_ma, ebe[i], ewd[i], ema[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic        wes[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s[7] = '{3'd2, 3'd1, 3'd5, 3'd3, 3'd6, 3'd2, 3'd7};
    logic [31:0] ads[7] = '{32'h102, 32'h101, 32'h103, 32'h100, 32'h100, 32'h0A1, 32'h0A0};
    int lat;
    set_mem(0, 0, 32'hFFFFFFFF);
    for (int i = 0; i < 7; i++) begin
      xact(wes[i], f3s[i], ads[i], 32'h1, 0, lat);
      checks++;
      if ({cap_seen, lat} !== {1'b0, 32'd1}) begin
        errors++; $display("FAIL err_nomem[%0d]: got memreq_seen=%b lat=%0d expected 0 1", i, cap_seen, lat);
      end
    end
  endtask

  task automatic test_slow;
    int lat;
    set_mem(2, 3, 32'h55AA33CC);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL slow_latency: got %0d expected 8", lat); end
    set_mem(1, 0, 32'h55AA33CC);
    xact(1'b0, 3'd5, 32'h12, 32'h0, 0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL slow_latency2: got %0d expected 4", lat); end
    // stray completion while idle must not produce a response or touch data
    mem_auto = 0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1; mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, stall, rsp_rdata} !== {2'b00, 32'h000055AA}) begin
      errors++; $display("FAIL stray_rvalid: got v=%b stall=%b rdata=%h expected 0 0 000055aa",
                         rsp_valid, stall, rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [32:0] e;
    int lat;
    set_mem(0, 0, 32'hA5A50F0F);
    for (int i = 0; i < 12; i++) begin
      we = 1'($urandom); f3 = 3'($urandom); addr = {24'h0, 8'($urandom)};
      e = model(we, addr, f3, mem_word);
      xact(we, f3, addr, $urandom, 0, lat);
      checks++;
      if (lat !== (e[32] ? 1 : 3)) begin
        errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d (we=%b f3=%0d addr=%h)",
                           i, lat, e[32] ? 1 : 3, we, f3, addr);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit saw;
    set_mem(-1, 0, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h200;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, stall} !== 2'b11) begin
      errors++; $display("FAIL mid_hold: got mem_req=%b stall=%b expected 1 1", mem_req, stall);
    end
    @(posedge clk); #1;
    mem_auto = 0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stall, mem_req, rsp_valid, rsp_rdata, mem_addr} !== 67'h0) begin
      errors++; $display("FAIL mid_reset: got stall=%b req=%b v=%b rdata=%h addr=%h expected all 0",
                         stall, mem_req, rsp_valid, rsp_rdata, mem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1; mem_rvalid = 1'b0;
    saw = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid) saw = 1; end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL mid_late_rvalid: got rsp_valid=1 expected 0"); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int lat;
`ifdef MEM_IF_TIMEOUT_EN
    set_mem(0, -1, 32'h0);
    xact(1'b0, 3'd2, 32'h300, 32'h0, 1, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL timeout_wait: got %0d expected 5", lat); end
    set_mem(-1, 0, 32'h0);
    xact(1'b1, 3'd2, 32'h304, 32'h1, 1, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL timeout_req: got %0d expected 5", lat); end
    set_mem(0, 0, 32'h13579BDF);
    xact(1'b0, 3'd2, 32'h308, 32'h0, 0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL timeout_recover: got %0d expected 3", lat); end
`else
    bit saw;
    set_mem(0, -1, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300;
    @(posedge clk); #1; req_valid = 1'b0;
    saw = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid || !stall) saw = 1; end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL no_timeout: got response/unstall, expected indefinite wait"); end
    mem_auto = 0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    lat = 0;
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_errors();
    test_slow();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
